// File: rtl/regfile_dump.sv
// Register-file debug read-out: walks first_sel..last_sel and streams each value on valid/ready.
// Optional running XOR checksum of sent beats when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump #(
    parameter int unsigned REG_DATA_WIDTH = 32,
    parameter int unsigned REG_SEL_BITS   = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [REG_SEL_BITS-1:0]   first_sel,
    input  logic [REG_SEL_BITS-1:0]   last_sel,
    output logic [REG_SEL_BITS-1:0]   read_sel,
    input  logic [REG_DATA_WIDTH-1:0] read_data,
    output logic                      dump_valid,
    input  logic                      dump_ready,
    output logic [REG_DATA_WIDTH-1:0] dump_data,
    output logic [REG_SEL_BITS-1:0]   dump_index,
    output logic                      dump_last,
    output logic                      busy,
    output logic                      done,
    output logic                      range_err,
    output logic [REG_DATA_WIDTH-1:0] dump_checksum
);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

    state_e                    state_q, state_d;
    logic [REG_SEL_BITS-1:0]   first_q, first_d;
    logic [REG_SEL_BITS-1:0]   last_q, last_d;
    logic [REG_SEL_BITS-1:0]   index_q, index_d;
    logic [REG_DATA_WIDTH-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      handshake;

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        last_d    = last_q;
        index_d   = index_q;
        data_d    = data_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        handshake = 1'b0;
        read_sel  = first_sel;
        unique case (state_q)
            StIdle: begin
                read_sel = first_sel;
                if (start) begin
                    if (first_sel <= last_sel) begin
                        first_d = first_sel;
                        last_d  = last_sel;
                        state_d = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                read_sel = first_q;
                data_d   = read_data;
                index_d  = first_q;
                valid_d  = 1'b1;
                state_d  = StSend;
            end
            StSend: begin
                // Pre-select the next index so its data is ready at the handshake edge.
                read_sel  = index_q + REG_SEL_BITS'(1);
                handshake = valid_q & dump_ready;
                if (handshake) begin
                    if (index_q == last_q) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        data_d  = read_data;
                        index_d = index_q + REG_SEL_BITS'(1);
                    end
                end
            end
            StDone: begin
                read_sel = first_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            first_q <= '0;
            last_q  <= '0;
            index_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
            index_q <= index_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dump_valid = valid_q;
    assign dump_data  = data_q;
    assign dump_index = index_q;
    assign dump_last  = valid_q & (index_q == last_q);
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign range_err  = err_q;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic                      accept;
    logic [REG_DATA_WIDTH-1:0] csum_q;

    assign accept = (state_q == StIdle) & start & (first_sel <= last_sel);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (handshake) begin
            csum_q <= csum_q ^ data_q;
        end
    end

    assign dump_checksum = csum_q;
`else
    assign dump_checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: table of dump ranges plus reset, start-while-busy
// and checksum sequences against a small register-file model.
module tb_regfile_dump;

    logic        clock;
    logic        reset;
    logic        start;
    logic [4:0]  first_sel;
    logic [4:0]  last_sel;
    logic [4:0]  read_sel;
    logic [31:0] read_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [4:0]  dump_index;
    logic        dump_last;
    logic        busy;
    logic        done;
    logic        range_err;
    logic [31:0] dump_checksum;

    logic [31:0] regs [32];
    int          n_vec;
    int          n_err;

    assign read_data = regs[read_sel];

    regfile_dump #(
        .REG_DATA_WIDTH(32),
        .REG_SEL_BITS  (5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .first_sel    (first_sel),
        .last_sel     (last_sel),
        .read_sel     (read_sel),
        .read_data    (read_data),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_data    (dump_data),
        .dump_index   (dump_index),
        .dump_last    (dump_last),
        .busy         (busy),
        .done         (done),
        .range_err    (range_err),
        .dump_checksum(dump_checksum)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]  f;
        logic [4:0]  l;
        logic [15:0] rpat;
        bit          err;
        int          cyc;
        bit          poke;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input logic [15:0] rpat,
                            input bit err, input int exp_cyc, input bit poke);
        int          beats;
        int          cyc;
        int          pi;
        bit          got_done;
        bit          prev_final;
        logic [31:0] csum;
        logic [31:0] exp_csum;
        logic [4:0]  ei;
        first_sel  = f;
        last_sel   = l;
        start      = 1'b1;
        dump_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        if (err) begin
            chk("range_err_pulse", 32'(range_err), 32'd1);
            chk("err_busy", 32'(busy), 32'd0);
            chk("err_valid", 32'(dump_valid), 32'd0);
            @(negedge clock);
            chk("range_err_clear", 32'(range_err), 32'd0);
            chk("err_valid2", 32'(dump_valid), 32'd0);
            chk("err_busy2", 32'(busy), 32'd0);
            return;
        end
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_valid", 32'(dump_valid), 32'd0);
        beats      = 0;
        cyc        = 0;
        got_done   = 1'b0;
        prev_final = 1'b0;
        csum       = '0;
        dump_ready = rpat[0];
        pi         = 1;
        while (!got_done && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (poke) begin
                if (cyc == 2) begin
                    start     = 1'b1;
                    first_sel = 5'd20;
                    last_sel  = 5'd25;
                end else if (cyc == 3) begin
                    start = 1'b0;
                end
            end
            dump_ready = rpat[pi[3:0]];
            pi++;
            if (prev_final) chk("done_after_last", 32'(done), 32'd1);
            if (done) begin
                got_done = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                exp_csum = csum;
`else
                exp_csum = '0;
`endif
                chk("beat_count", 32'(beats), 32'(l - f + 1));
                if (exp_cyc != 0) chk("done_cycle", 32'(cyc), 32'(exp_cyc));
                chk("done_valid", 32'(dump_valid), 32'd0);
                chk("done_busy", 32'(busy), 32'd1);
                chk("checksum_at_done", dump_checksum, exp_csum);
            end else begin
                chk("send_valid", 32'(dump_valid), 32'd1);
                ei = f + 5'(beats);
                chk("beat_index", 32'(dump_index), 32'(ei));
                chk("beat_data", dump_data, regs[ei]);
                chk("beat_last", 32'(dump_last), 32'(ei == l));
                prev_final = 1'b0;
                if (dump_valid && dump_ready) begin
                    csum       = csum ^ dump_data;
                    beats++;
                    prev_final = (ei == l);
                end
            end
        end
        if (!got_done) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clock);
            chk("done_clear", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("checksum_hold", dump_checksum, exp_csum);
        end
        dump_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 32'h11);

        //       first  last   ready pattern  err   cycles poke
        vecs[0] = '{5'd0,  5'd31, 16'hFFFF, 1'b0, 33, 1'b0};
        vecs[1] = '{5'd4,  5'd6,  16'hFFD3, 1'b0, 7,  1'b0};
        vecs[2] = '{5'd7,  5'd7,  16'hFFFF, 1'b0, 2,  1'b0};
        vecs[3] = '{5'd9,  5'd3,  16'hFFFF, 1'b1, 0,  1'b0};
        vecs[4] = '{5'd2,  5'd5,  16'hFFFF, 1'b0, 5,  1'b1};
        vecs[5] = '{5'd28, 5'd31, 16'hAAAA, 1'b0, 0,  1'b0};
        vecs[6] = '{5'd0,  5'd0,  16'hFFF9, 1'b0, 4,  1'b0};

        reset      = 1'b0;
        start      = 1'b0;
        first_sel  = '0;
        last_sel   = '0;
        dump_ready = 1'b0;
        #1;
        chk("rst_read_sel", 32'(read_sel), 32'd0);
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_data", dump_data, 32'd0);
        chk("rst_index", 32'(dump_index), 32'd0);
        chk("rst_last", 32'(dump_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_range_err", 32'(range_err), 32'd0);
        chk("rst_checksum", dump_checksum, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int v = 0; v < 7; v++) begin
            run_dump(vecs[v].f, vecs[v].l, vecs[v].rpat, vecs[v].err, vecs[v].cyc, vecs[v].poke);
            @(negedge clock);
        end

        // Reset pulled low right after beat 10 is accepted.
        first_sel  = 5'd0;
        last_sel   = 5'd31;
        start      = 1'b1;
        dump_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (11) @(negedge clock);
        chk("pre_rst_index", 32'(dump_index), 32'd10);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(dump_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_index", 32'(dump_index), 32'd0);
        chk("midrst_data", dump_data, 32'd0);
        chk("midrst_read_sel", 32'(read_sel), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        reset      = 1'b1;
        dump_ready = 1'b0;
        @(negedge clock);
        run_dump(5'd0, 5'd31, 16'hFFFF, 1'b0, 33, 1'b0);
        @(negedge clock);

        // Checksum sequence: 0xA5 ^ 0x0F ^ 0xF0 = 0x5A.
        regs[1] = 32'hA5;
        regs[2] = 32'h0F;
        regs[3] = 32'hF0;
        run_dump(5'd1, 5'd3, 16'hFFFF, 1'b0, 4, 1'b0);
`ifdef REGFILE_DUMP_CHECKSUM_EN
        chk("checksum_5a", dump_checksum, 32'h5A);
`else
        chk("checksum_tied_zero", dump_checksum, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
